// File: rtl/inst_mem_server_if.sv
// Request/response handshake bundle between the instruction-memory client
// (master) and the memory server (slave).
interface inst_mem_server_if #(
  parameter int unsigned p_opaque_bits = 8
);
  logic                     req_val;
  logic                     req_rdy;
  logic                     req_op;
  logic [31:0]              req_addr;
  logic [31:0]              req_data;
  logic [3:0]               req_strb;
  logic [p_opaque_bits-1:0] req_opaque;

  logic                     resp_val;
  logic                     resp_rdy;
  logic                     resp_op;
  logic [p_opaque_bits-1:0] resp_opaque;
  logic [31:0]              resp_data;

  modport master (
    output req_val, req_op, req_addr, req_data, req_strb, req_opaque, resp_rdy,
    input  req_rdy, resp_val, resp_op, resp_opaque, resp_data
  );

  modport slave (
    input  req_val, req_op, req_addr, req_data, req_strb, req_opaque, resp_rdy,
    output req_rdy, resp_val, resp_op, resp_opaque, resp_data
  );
endinterface

// File: rtl/inst_mem_server.sv
// Word-addressed memory server: accepts read/write requests, accesses the
// array at the request-fire edge, and returns in-order responses through a
// fixed-latency valid pipeline feeding a credit-limited response FIFO.
module inst_mem_server #(
  parameter int unsigned p_depth_words = 256,
  parameter int unsigned p_latency     = 2,
  parameter int unsigned p_resp_buf    = 4,
  parameter int unsigned p_opaque_bits = 8
) (
  input  logic               clk,
  input  logic               rst,
  inst_mem_server_if.slave   bus
);

  localparam int unsigned AW = $clog2(p_depth_words);
  localparam int unsigned OW = $clog2(p_resp_buf + 1);
  localparam int unsigned PW = (p_resp_buf > 1) ? $clog2(p_resp_buf) : 1;
  localparam logic [OW-1:0] BUF_MAX  = OW'(p_resp_buf);
  localparam logic [PW-1:0] PTR_LAST = PW'(p_resp_buf - 1);

  if (p_latency < 1 || p_resp_buf < p_latency || p_depth_words < 2 ||
      (p_depth_words & (p_depth_words - 1)) != 0) begin : g_bad_param
    $error("inst_mem_server: illegal parameter combination");
  end

  logic                     req_fire;
  logic                     resp_fire;
  logic                     push;
  logic [AW-1:0]            idx;

  logic [31:0]              mem_q [p_depth_words];

  logic [p_latency-1:0]     pipe_val_q, pipe_val_d;
  logic                     pipe_op_q   [p_latency];
  logic [p_opaque_bits-1:0] pipe_opq_q  [p_latency];
  logic [31:0]              pipe_data_q [p_latency];

  logic                     fifo_op_q   [p_resp_buf];
  logic [p_opaque_bits-1:0] fifo_opq_q  [p_resp_buf];
  logic [31:0]              fifo_data_q [p_resp_buf];

  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [OW-1:0]            cnt_q, cnt_d;
  logic [OW-1:0]            out_q, out_d;

  logic                     unused_addr_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign idx              = bus.req_addr[2 +: AW];
  assign unused_addr_bits = &{1'b0, bus.req_addr};

  // rst gating keeps req_rdy low while reset is held even though out_q is 0
  assign bus.req_rdy  = rst & (out_q < BUF_MAX);
  assign bus.resp_val = (cnt_q != '0);
  assign bus.resp_op     = fifo_op_q[head_q];
  assign bus.resp_opaque = fifo_opq_q[head_q];
  assign bus.resp_data   = fifo_data_q[head_q];

  assign req_fire  = bus.req_val & bus.req_rdy;
  assign resp_fire = bus.resp_val & bus.resp_rdy;
  assign push      = pipe_val_q[p_latency-1];

  // Byte-masked write into the array on a write-request fire; contents survive reset
  always_ff @(posedge clk) begin
    if (req_fire && bus.req_op) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.req_strb[b]) begin
          mem_q[idx][8*b +: 8] <= bus.req_data[8*b +: 8];
        end
      end
    end
  end

  // Next-state for pipeline valids, credit counter, FIFO occupancy and pointers
  always_comb begin
    pipe_val_d    = pipe_val_q;
    pipe_val_d[0] = req_fire;
    for (int unsigned i = 1; i < p_latency; i++) begin
      pipe_val_d[i] = pipe_val_q[i-1];
    end

    out_d = out_q;
    if (req_fire && !resp_fire) begin
      out_d = out_q + 1'b1;
    end else if (!req_fire && resp_fire) begin
      out_d = out_q - 1'b1;
    end

    cnt_d = cnt_q;
    if (push && !resp_fire) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && resp_fire) begin
      cnt_d = cnt_q - 1'b1;
    end

    tail_d = push ? ptr_inc(tail_q) : tail_q;
    head_d = resp_fire ? ptr_inc(head_q) : head_q;
  end

  // Control state register; reset discards everything in flight or buffered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_val_q <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      pipe_val_q <= pipe_val_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Response payload pipeline: stage 0 captures read data at the fire edge
  always_ff @(posedge clk) begin
    pipe_op_q[0]   <= bus.req_op;
    pipe_opq_q[0]  <= bus.req_opaque;
    pipe_data_q[0] <= bus.req_op ? '0 : mem_q[idx];
    for (int unsigned i = 1; i < p_latency; i++) begin
      pipe_op_q[i]   <= pipe_op_q[i-1];
      pipe_opq_q[i]  <= pipe_opq_q[i-1];
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
  end

  // FIFO storage write; credits bound occupancy so a push always has room
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op_q[tail_q]   <= pipe_op_q[p_latency-1];
      fifo_opq_q[tail_q]  <= pipe_opq_q[p_latency-1];
      fifo_data_q[tail_q] <= pipe_data_q[p_latency-1];
    end
  end

endmodule

// File: tb/tb_inst_mem_server.sv
// Directed bench for inst_mem_server with a response scoreboard.
module tb_inst_mem_server;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  inst_mem_server_if #(.p_opaque_bits(8)) bus ();

  inst_mem_server #(
    .p_depth_words(256),
    .p_latency(2),
    .p_resp_buf(4),
    .p_opaque_bits(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        op;
    logic [7:0]  opq;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model_mem [256];
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          n_resp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one request at the current point (between edges); record expectation if it fires.
  task automatic issue(input logic op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [7:0] opq, output logic fired);
    logic [7:0] ix;
    exp_t       e;
    ix             = addr[9:2];
    bus.req_val    = 1'b1;
    bus.req_op     = op;
    bus.req_addr   = addr;
    bus.req_data   = data;
    bus.req_strb   = strb;
    bus.req_opaque = opq;
    fired          = bus.req_rdy;
    if (fired) begin
      e.op  = op;
      e.opq = opq;
      if (op) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) model_mem[ix][8*b +: 8] = data[8*b +: 8];
        end
        e.data = 32'h0;
      end else begin
        e.data = model_mem[ix];
      end
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_val = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor: sample 1ns before each rising edge
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (rst && bus.resp_val && bus.resp_rdy) begin
      n_resp++;
      if (sb.size() == 0) begin
        check("unexpected_resp_sb_size", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("resp_op", 32'(bus.resp_op), 32'(e.op));
        check("resp_opaque", 32'(bus.resp_opaque), 32'(e.opq));
        check("resp_data", bus.resp_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic f;
    int   acc;
    int   n0;
    logic [7:0] o1;

    rst            = 1'b0;
    bus.req_val    = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.req_strb   = '0;
    bus.req_opaque = '0;
    bus.resp_rdy   = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("rst_resp_val", 32'(bus.resp_val), 32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_req_rdy", 32'(bus.req_rdy), 32'd1);
    @(negedge clk);

    // 1: write then read, latency check
    issue(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 8'd3, f);
    check("t1_wr_fire", 32'(f), 32'd1);
    check("t1_lat_after_fire", 32'(bus.resp_val), 32'd0);
    issue(1'b0, 32'h100, 32'h0, 4'h0, 8'd4, f);
    check("t1_rd_fire", 32'(f), 32'd1);
    check("t1_lat_1cyc", 32'(bus.resp_val), 32'd0);
    idle();
    @(negedge clk);
    check("t1_lat_2cyc", 32'(bus.resp_val), 32'd1);
    check("t1_wr_resp_data", bus.resp_data, 32'h0);
    drain();

    // 2: byte strobes and misaligned read
    issue(1'b1, 32'h20, 32'h11223344, 4'hF, 8'd5, f);
    issue(1'b1, 32'h20, 32'h0000AA00, 4'h2, 8'd6, f);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 8'd7, f);
    issue(1'b0, 32'h23, 32'h0, 4'h0, 8'd8, f);
    idle();
    check("t2_model_merge", model_mem[8], 32'h1122AA44);
    drain();

    // 3: throughput, 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, (i % 2 == 0) ? 32'h100 : 32'h20, 32'h0, 4'h0, 8'(i), f);
      check("t3_req_rdy", 32'(f), 32'd1);
      check("t3_resp_val", 32'(bus.resp_val), (i >= 2) ? 32'd1 : 32'd0);
    end
    idle();
    @(negedge clk);
    check("t3_resp_val_k8", 32'(bus.resp_val), 32'd1);
    @(negedge clk);
    check("t3_resp_val_k9", 32'(bus.resp_val), 32'd1);
    @(negedge clk);
    check("t3_resp_val_k10", 32'(bus.resp_val), 32'd0);
    drain();

    // 4: backpressure, credit limit
    #2 bus.resp_rdy = 1'b0;
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 32'h100, 32'h0, 4'h0, 8'(16 + i), f);
      acc += int'(f);
    end
    idle();
    check("t4_accepted", 32'(acc), 32'd4);
    check("t4_req_rdy_full", 32'(bus.req_rdy), 32'd0);
    check("t4_resp_val_held", 32'(bus.resp_val), 32'd1);
    o1 = bus.resp_opaque;
    @(negedge clk);
    check("t4_opaque_stable", 32'(bus.resp_opaque), 32'(o1));
    check("t4_resp_val_stable", 32'(bus.resp_val), 32'd1);
    n0 = n_resp;
    #2 bus.resp_rdy = 1'b1;
    check("t4_req_rdy_same_cycle", 32'(bus.req_rdy), 32'd0);
    @(negedge clk);
    check("t4_req_rdy_next_cycle", 32'(bus.req_rdy), 32'd1);
    drain();
    check("t4_resp_count", 32'(n_resp - n0), 32'd4);

    // 5: aliasing modulo depth
    issue(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 8'd30, f);
    issue(1'b0, 32'h0, 32'h0, 4'h0, 8'd31, f);
    idle();
    drain();

    // 6: reset mid-flight
    #2 bus.resp_rdy = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) issue(1'b0, 32'h0, 32'h0, 4'h0, 8'(40 + i), f);
    idle();
    repeat (2) @(negedge clk);
    check("t6_resp_val_before", 32'(bus.resp_val), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_resp_val_in_rst", 32'(bus.resp_val), 32'd0);
    check("t6_req_rdy_in_rst", 32'(bus.req_rdy), 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    bus.resp_rdy = 1'b1;
    #1;
    check("t6_req_rdy_after", 32'(bus.req_rdy), 32'd1);
    n0 = n_resp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_resp_val_quiet", 32'(bus.resp_val), 32'd0);
    end
    check("t6_no_stale_resp", 32'(n_resp - n0), 32'd0);
    issue(1'b0, 32'h0, 32'h0, 4'h0, 8'd50, f);
    check("t6_rd_fire", 32'(f), 32'd1);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 8'd51, f);
    idle();
    drain();
    check("t6_resp_count", 32'(n_resp - n0), 32'd2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_mem_server.md
Name: inst_mem_server

Overview:
- Word-addressed instruction/data memory model that serves the processor's instruction-memory client port: accepts read/write requests and returns in-order responses after a fixed pipeline latency.
- Sits directly upstream of the fetch unit, on the far side of the top-level instruction-memory interface.
- Credit-limited response buffer absorbs client backpressure without losing responses.
- Used in simulation top-levels and as the FPGA on-chip memory.

Parameters:
- p_depth_words, 256, number of 32-bit words; power of two, at least 2.
- p_latency, 2, cycles from request handshake to earliest resp_val; at least 1.
- p_resp_buf, 4, maximum outstanding requests (response FIFO entries); at least p_latency.
- p_opaque_bits, 8, width of the opaque tag echoed unchanged in the response.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: asynchronous, active-low.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_op  in  1  0 = read, 1 = write.
- req_addr  in  32  byte address.
- req_data  in  32  write data.
- req_strb  in  4  byte-enable for writes; bit i enables byte i.
- req_opaque  in  p_opaque_bits  tag echoed in the response.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_op  out  1  echoed op.
- resp_opaque  out  p_opaque_bits  echoed tag.
- resp_data  out  32  read data; 0 for writes.

Behaviour:
- Handshakes:
  - Request fires when req_val and req_rdy are both high at a rising edge.
  - Response fires when resp_val and resp_rdy are both high at a rising edge.
  - Once resp_val is high, it stays high and the response fields are held stable until the response fires.
- Addressing:
  - Word index is req_addr[2 +: log2(p_depth_words)].
  - req_addr[1:0] is ignored.
  - Address bits above the index are ignored, so addresses alias modulo the memory size.
- Access timing: the memory array is accessed at the request-fire edge.
  - Write: each byte with its req_strb bit set is updated; a write with strb 0 updates nothing but still produces a response.
  - Read: captures the array contents as they stand after all previously fired requests have taken effect, so a read fired in the cycle after a write to the same word returns the new data.
- Latency and ordering:
  - A request fired at edge t gives resp_val high in cycle t+p_latency when nothing ahead of it is stalled.
  - With resp_rdy held high, the block sustains one request and one response per cycle.
  - Responses are strictly in request order.
- Credit counter: outstanding, width clog2(p_resp_buf+1).
  - Increments on request fire; decrements on response fire; unchanged when both fire in the same cycle.
  - req_rdy = (outstanding < p_resp_buf). It depends on registered state only: no combinational path from req_val or resp_rdy to any output.
- Buffering:
  - In-flight responses travel a p_latency-stage valid pipeline into a p_resp_buf-entry circular FIFO with head and tail pointers that wrap modulo p_resp_buf.
  - The credit counter guarantees the FIFO never overflows, so there is no drop path.
  - resp_val = FIFO not empty, after the pipeline delay.
- Full / empty:
  - With outstanding = p_resp_buf: req_rdy is low. A response fire in that cycle raises req_rdy in the next cycle, not the same cycle.
  - With FIFO empty: resp_val is low and resp_data, resp_op, resp_opaque are don't-care.
- Reset (rst low, asynchronous):
  - req_rdy = 0, resp_val = 0.
  - outstanding = 0, all pipeline valids cleared, FIFO pointers = 0.
  - Memory contents are not reset.
  - After rst deasserts, req_rdy is 1 in the first cycle.
- Reset mid-operation: in-flight and buffered responses are discarded; no response for them ever appears.
- Out-of-range parameters fail elaboration via a static assertion: p_latency < 1, p_resp_buf < p_latency, or p_depth_words not a power of two.

Test Plan (defaults unless stated):
1. Write then read, resp_rdy = 1:
   - Write 0xDEADBEEF to 0x100, strb 0xF, opaque 3 -> write response (op 1, opaque 3, data 0) arrives 2 cycles after fire.
   - Read 0x100 in the next cycle, opaque 4 -> data 0xDEADBEEF, op 0, opaque 4.
2. Byte strobes:
   - Write 0x11223344 to 0x20, strb 0xF.
   - Write 0x0000AA00 to 0x20, strb 0x2.
   - Read 0x20 -> 0x1122AA44.
   - Read 0x23 (misaligned) -> same data.
3. Throughput:
   - 8 back-to-back reads, opaque 0..7, resp_rdy = 1 -> req_rdy never drops.
   - resp_val high on 8 consecutive cycles starting 2 cycles after the first fire; opaque order 0..7.
4. Backpressure:
   - resp_rdy = 0, drive continuous read requests -> exactly 4 accepted, then req_rdy = 0.
   - Raise resp_rdy -> 4 responses in order; req_rdy returns 1 the cycle after the first response fires.
   - No response lost or duplicated.
5. Aliasing:
   - Write 0xCAFEF00D to 0x400 (depth 256) -> read 0x0 returns 0xCAFEF00D.
6. Reset mid-flight:
   - Issue 3 reads with resp_rdy = 0, then pull rst low for 1 cycle -> resp_val and req_rdy go 0 immediately.
   - After release: req_rdy = 1, resp_val stays 0 until a new request; memory data written before the reset is still readable.
